multicycle_control: RTL and testbench

- Moore FSM that sequences a shared-memory, multi-cycle MIPS datapath: one memory port, IR, A/B, ALUOut and MDR registers.
- Replaces the single-cycle decode-only control.
- Decodes op, steps each instruction through fetch/decode/execute/memory/writeback, and stalls on a memory ready handshake.
- Flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_control.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-memory multi-cycle MIPS datapath.
// Steps fetch/decode/execute/memory/writeback, stalls on mem_ready, flags bad opcodes and memory timeouts.
module multicycle_control #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       memto_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);
  localparam int unsigned CW = 8;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_t;

  state_t        st, nxt;
  logic [CW-1:0] wait_cnt;
  logic          waiting, limit, bad_op;

  // A memory state without mem_ready this cycle; limit is the last allowed wait cycle.
  always_comb begin
    waiting = ((st == FETCH) || (st == MEMRD) || (st == MEMWR)) && !mem_ready;
    limit   = waiting && (wait_cnt == CW'(MAX_WAIT - 1));
  end

  always_comb begin
    nxt    = st;
    bad_op = 1'b0;
    case (st)
      FETCH:  if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_R:          nxt = EXEC;
          OP_LW, OP_SW:  nxt = MEMADR;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_ADDI:       nxt = ADDIEX;
          OP_J:          nxt = JUMP;
          default: begin
            nxt    = FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)  nxt = MEMWB;
        else if (limit) nxt = FETCH;
      end
      MEMWR:  if (mem_ready || limit) nxt = FETCH;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= FETCH;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      st          <= nxt;
      wait_cnt    <= (waiting && !limit) ? wait_cnt + CW'(1) : '0;
      illegal_op  <= illegal_op | bad_op;
      mem_timeout <= mem_timeout | limit;
    end
  end

  // Moore decode; FETCH load enables also follow mem_ready and are held off while reset is asserted.
  always_comb begin
    pc_en     = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_dst   = 1'b0;
    memto_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    pc_src    = 2'b00;
    case (st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready && !reset;
        pc_en     = mem_ready && !reset;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = (op == OP_BNE) ? !zero : zero;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors push expected
// state/control words, a negedge monitor pops and compares.
module tb_multicycle_control;
  localparam int unsigned MAX_WAIT = 8;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   idx = 0;
  logic e_ill = 1'b0;
  logic e_tmo = 1'b0;

  // Expected control word from the documented per-state output table.
  // Order: pc_en iord mem_read mem_write ir_write reg_dst memto_reg reg_write alu_src_a alu_src_b alu_op pc_src illegal timeout
  function automatic logic [16:0] model(input logic [3:0] s, input logic r, input logic mr,
                                        input logic z, input logic [5:0] o);
    logic pe, io, mrd, mwr, irw, rd, m2r, rw, sa;
    logic [1:0] sb, ao, ps;
    {pe, io, mrd, mwr, irw, rd, m2r, rw, sa} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      4'd0:  begin mrd = 1'b1; sb = 2'b01; irw = mr & ~r; pe = mr & ~r; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  begin mrd = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; io = 1'b1; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = (o == OP_BEQ) ? z : ~z; end
      4'd9:  begin sa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ao, ps, e_ill, e_tmo};
  endfunction

  task automatic step(input logic r, input logic mr, input logic z, input logic [5:0] o,
                      input logic [3:0] es);
    exp_t e;
    reset = r; mem_ready = mr; zero = z; op = o;
    e.st = es;
    e.ctrl = model(es, r, mr, z, o);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic s(input logic mr, input logic [5:0] o, input logic [3:0] es);
    step(1'b0, mr, 1'b0, o, es);
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [16:0] got;
      e = exp_q.pop_front();
      got = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, memto_reg, reg_write,
             alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, mem_timeout};
      checks++;
      if (state !== e.st) begin
        failures++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d", idx, state, e.st);
      end
      checks++;
      if (got !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl cyc=%0d state=%0d got=%05h exp=%05h", idx, state, got, e.ctrl);
      end
      idx++;
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = OP_R;
    repeat (2) @(posedge clk);
    #1;
    // reset held: FETCH, load enables suppressed, flags clear
    step(1'b1, 1'b1, 1'b0, OP_R, 4'd0);
    // R-type: 0,1,6,7
    s(1, OP_R, 0); s(1, OP_R, 1); s(1, OP_R, 6); s(1, OP_R, 7);
    // lw with two MEMRD wait cycles: 0,1,2,3,3,3,4
    s(1, OP_LW, 0); s(1, OP_LW, 1); s(1, OP_LW, 2);
    s(0, OP_LW, 3); s(0, OP_LW, 3); s(1, OP_LW, 3); s(1, OP_LW, 4);
    // beq zero=1 takes, bne zero=1 does not
    step(0, 1, 1, OP_BEQ, 0); step(0, 1, 1, OP_BEQ, 1); step(0, 1, 1, OP_BEQ, 8);
    step(0, 1, 1, OP_BNE, 0); step(0, 1, 1, OP_BNE, 1); step(0, 1, 1, OP_BNE, 8);
    step(0, 1, 0, OP_BNE, 0); step(0, 1, 0, OP_BNE, 1); step(0, 1, 0, OP_BNE, 8);
    // jump
    s(1, OP_J, 0); s(1, OP_J, 1); s(1, OP_J, 11);
    // addi with two fetch wait cycles
    s(0, OP_ADDI, 0); s(0, OP_ADDI, 0); s(1, OP_ADDI, 0);
    s(1, OP_ADDI, 1); s(1, OP_ADDI, 9); s(1, OP_ADDI, 10);
    // sw, mem_ready on the 8th wait-limit cycle: no timeout
    s(1, OP_SW, 0); s(1, OP_SW, 1); s(1, OP_SW, 2);
    for (int i = 0; i < 7; i++) s(0, OP_SW, 5);
    s(1, OP_SW, 5);
    // sw, mem_ready never arrives: timeout after 8 cycles
    s(1, OP_SW, 0); s(1, OP_SW, 1); s(1, OP_SW, 2);
    for (int i = 0; i < 8; i++) s(0, OP_SW, 5);
    e_tmo = 1'b1;
    // illegal opcode back to FETCH, flag stays set
    s(1, OP_BAD, 0); s(1, OP_BAD, 1);
    e_ill = 1'b1;
    s(1, OP_R, 0); s(1, OP_R, 1); s(1, OP_R, 6); s(1, OP_R, 7);
    // reset mid MEMRD: asynchronous return to FETCH, flags cleared
    s(1, OP_LW, 0); s(1, OP_LW, 1); s(1, OP_LW, 2); s(0, OP_LW, 3);
    e_ill = 1'b0; e_tmo = 1'b0;
    step(1'b1, 1'b1, 1'b0, OP_LW, 4'd0);
    step(1'b1, 1'b0, 1'b0, OP_LW, 4'd0);
    // fetch timeout restarts the fetch
    for (int i = 0; i < 8; i++) s(0, OP_ADDI, 0);
    e_tmo = 1'b1;
    s(1, OP_ADDI, 0); s(1, OP_ADDI, 1); s(1, OP_ADDI, 9); s(1, OP_ADDI, 10);
    s(0, OP_ADDI, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
